gray_conv_ctrl: RTL and testbench

Sequencing controller for the 8-bit bit-serial binary/Gray converter datapath. It accepts a start/mode command and drives the datapath register loads, operand-select and bit-index controls to convert one byte MSB-first. On completion it reports done and result-valid; the result is read from the datapath output register.

---
 rtl/gray_conv_pkg.sv | 38 +++
 rtl/gray_conv_ctrl.sv | 129 ++++++++++++
 tb/tb_gray_conv_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/gray_conv_pkg.sv
// Shared types and constants for the bit-serial binary/Gray converter.
// Imported by the sequencing controller and by anything that drives it.
package gray_conv_pkg;

    localparam int CONV_WIDTH = 8;
    localparam int CONV_MSB   = CONV_WIDTH - 1;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MSB   = 3'd1,
        FETCH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Operand-select bundle the datapath sees while a conversion is running.
    typedef struct packed {
        logic r1_bit_sel;
        logic use_r1_for_r3;
        logic use_r1_for_r4;
    } sel_t;

    // B2G xors neighbouring input bits; G2B xors the input bit with the
    // result bit just above it.
    function automatic sel_t mode_sel(input logic m);
        sel_t s;
        if (m == MODE_B2G) begin
            s = '{r1_bit_sel: 1'b1, use_r1_for_r3: 1'b1, use_r1_for_r4: 1'b1};
        end else begin
            s = '{r1_bit_sel: 1'b0, use_r1_for_r3: 1'b1, use_r1_for_r4: 1'b0};
        end
        return s;
    endfunction

endpackage

// File: rtl/gray_conv_ctrl.sv
// Sequencing FSM for the bit-serial binary/Gray converter: walks one byte
// MSB-first, driving register loads, operand selects and the bit index.
module gray_conv_ctrl
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = CONV_WIDTH,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic             R1_in,
    output logic             R2_in,
    output logic             R3_in,
    output logic             R4_in,
    output logic [IDX_W-1:0] bit_index,
    output logic             R1_bit_sel,
    output logic             load_R2_bit,
    output logic             use_R1_for_R3,
    output logic             use_R1_for_R4
);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             mode_q, mode_next;
    logic             result_valid_q, result_valid_next;
    sel_t             sel;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            mode_q         <= MODE_B2G;
            result_valid_q <= 1'b0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            mode_q         <= mode_next;
            result_valid_q <= result_valid_next;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no
        // path through the case statement can infer a latch.
        state_next        = state;
        idx_next          = idx;
        mode_next         = mode_q;
        result_valid_next = result_valid_q;
        busy              = 1'b0;
        done              = 1'b0;
        R1_in             = 1'b0;
        R3_in             = 1'b0;
        R4_in             = 1'b0;
        bit_index         = '0;
        load_R2_bit       = 1'b0;
        sel               = '0;

        case (state)
            IDLE: begin
                // Mealy load: data_in is captured on the edge that accepts start.
                R1_in = start;
                if (start) begin
                    state_next        = MSB;
                    mode_next         = mode;
                    idx_next          = IDX_W'(WIDTH - 2);
                    result_valid_next = 1'b0;
                end
            end
            MSB: begin
                busy        = 1'b1;
                bit_index   = IDX_W'(WIDTH - 1);
                load_R2_bit = 1'b1;
                sel         = mode_sel(mode_q);
                state_next  = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                bit_index  = idx;
                R3_in      = 1'b1;
                R4_in      = 1'b1;
                sel        = mode_sel(mode_q);
                state_next = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                bit_index   = idx;
                load_R2_bit = 1'b1;
                sel         = mode_sel(mode_q);
                // Bit 0 is the last one written; idx is left alone so it never wraps.
                if (idx == '0) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx - IDX_W'(1);
                    state_next = FETCH;
                end
            end
            DONE: begin
                done              = 1'b1;
                result_valid_next = 1'b1;
                state_next        = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A cancelled conversion never publishes a result.
        if (abort && (state != IDLE)) begin
            state_next        = IDLE;
            idx_next          = idx;
            result_valid_next = result_valid_q;
        end
    end

    assign result_valid  = result_valid_q;
    assign R2_in         = 1'b0;
    assign R1_bit_sel    = sel.r1_bit_sel;
    assign use_R1_for_R3 = sel.use_r1_for_r3;
    assign use_R1_for_R4 = sel.use_r1_for_r4;

endmodule

// File: tb/tb_gray_conv_ctrl.sv
// Self-checking bench for gray_conv_ctrl: a behavioural datapath executes the
// control stream and results are compared to arithmetic binary/Gray conversion.
module tb_gray_conv_ctrl;
    import gray_conv_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic       abort;
    logic [7:0] data_in;

    logic       busy, done, result_valid;
    logic       R1_in, R2_in, R3_in, R4_in;
    logic [2:0] bit_index;
    logic       R1_bit_sel, load_R2_bit, use_R1_for_R3, use_R1_for_R4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gray_conv_ctrl #(.WIDTH(8), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .busy(busy), .done(done), .result_valid(result_valid),
        .R1_in(R1_in), .R2_in(R2_in), .R3_in(R3_in), .R4_in(R4_in),
        .bit_index(bit_index), .R1_bit_sel(R1_bit_sel), .load_R2_bit(load_R2_bit),
        .use_R1_for_R3(use_R1_for_R3), .use_R1_for_R4(use_R1_for_R4)
    );

    logic [13:0] all_outs;
    assign all_outs = {busy, done, result_valid, R1_in, R2_in, R3_in, R4_in,
                       bit_index, R1_bit_sel, load_R2_bit, use_R1_for_R3, use_R1_for_R4};

    // Behavioural datapath that executes whatever the controller commands.
    logic [7:0] r1, r2;
    logic       r3, r4;
    logic [7:0] data_out;
    assign data_out = r2;

    function automatic logic bit_at(input logic [7:0] v, input int k);
        return (k >= 0 && k < 8) ? v[k] : 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= 1'b0;
            r4 <= 1'b0;
        end else begin
            if (R1_in) r1 <= data_in;
            if (R3_in)
                r3 <= use_R1_for_R3 ? bit_at(r1, int'(bit_index) + (R1_bit_sel ? 1 : 0)) : 1'b0;
            if (R4_in)
                r4 <= use_R1_for_R4 ? bit_at(r1, int'(bit_index)) : bit_at(r2, int'(bit_index) + 1);
            if (load_R2_bit)
                r2[bit_index] <= (bit_index == 3'd7) ? r1[7] : (r3 ^ r4);
        end
    end

    // Reference conversion from the code definitions, not the bit schedule.
    function automatic logic [7:0] ref_conv(input logic m, input logic [7:0] x);
        logic [7:0] y;
        if (m == MODE_B2G) begin
            y = x ^ (x >> 1);
        end else begin
            y = x;
            for (int s = 1; s < 8; s = s * 2) y = y ^ (y >> s);
        end
        return y;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start is applied in cycle 0; waits for done with a bounded cycle count.
    task automatic run_conv(input string tag, input logic m, input logic [7:0] d, input bit noise);
        int         cyc;
        bit         busy_ok;
        logic [7:0] exp;
        exp     = ref_conv(m, d);
        mode    = m;
        data_in = d;
        start   = 1'b1;
        step();
        start   = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (noise) begin
                mode    = 1'($urandom);
                data_in = 8'($urandom);
                start   = 1'($urandom);
            end
            step();
            cyc++;
        end
        start = 1'b1;
        check({tag, " done_cycle"}, cyc, 16);
        check({tag, " busy_window"}, 32'(busy_ok), 1);
        check({tag, " data_out"}, data_out, exp);
        check({tag, " busy_in_done"}, busy, 0);
        step();
        start = 1'b0;
        check({tag, " idle_after_done"}, {busy, result_valid}, 2'b01);
    endtask

    initial begin
        int n_done;

        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; data_in = 8'h00;
        #12 rst = 1'b0;
        #0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("reset_idle_%0d", i), all_outs, 0);
        end

        run_conv("b2g_B4", MODE_B2G, 8'hB4, 1'b0);
        run_conv("g2b_EE", MODE_G2B, 8'hEE, 1'b0);
        run_conv("g2b_80", MODE_G2B, 8'h80, 1'b0);
        run_conv("b2g_FF", MODE_B2G, 8'hFF, 1'b0);

        // Abort while idle is ignored; start beats a simultaneous abort.
        abort = 1'b1;
        step();
        check("idle_abort_keeps_valid", {busy, result_valid}, 2'b01);
        start = 1'b1; mode = MODE_B2G; data_in = 8'h01;
        step();
        start = 1'b0; abort = 1'b0;
        check("start_beats_abort", {busy, result_valid}, 2'b10);
        for (int i = 0; i < 20 && busy === 1'b1; i++) step();
        step();

        // Back-to-back with start held high the whole time.
        mode = MODE_B2G; data_in = 8'h00; start = 1'b1;
        step();
        data_in = 8'h5A;
        n_done = 1;
        while (done !== 1'b1 && n_done < 40) begin step(); n_done++; end
        check("b2b_first_done_cycle", n_done, 16);
        check("b2b_first_data", data_out, 8'h00);
        step();
        check("b2b_cycle17_accepting", {busy, R1_in}, 2'b01);
        step();
        n_done = 18;
        check("b2b_second_busy", busy, 1);
        while (done !== 1'b1 && n_done < 60) begin step(); n_done++; end
        start = 1'b0;
        check("b2b_second_done_cycle", n_done, 33);
        check("b2b_second_data", data_out, 8'h77);
        step();
        check("b2b_valid", result_valid, 1);

        // Abort in cycle 6.
        mode = MODE_B2G; data_in = 8'h12; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 6; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_to_idle", {busy, done, result_valid}, 3'b000);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) n_done++;
            step();
        end
        check("abort_no_done", n_done, 0);
        check("abort_valid_low", result_valid, 0);
        run_conv("after_abort_B4", MODE_B2G, 8'hB4, 1'b0);

        // Asynchronous reset mid-FETCH.
        mode = MODE_G2B; data_in = 8'hA5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("in_fetch_before_rst", R3_in, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_outs_zero", all_outs, 0);
        check("rst_datapath_zero", data_out, 0);
        #3 rst = 1'b0;
        step();
        check("rst_released_idle", all_outs, 0);
        run_conv("after_rst_3C", MODE_G2B, 8'h3C, 1'b0);

        // Random conversions with input noise while busy.
        for (int i = 0; i < 12; i++) begin
            run_conv($sformatf("rand_%0d", i), 1'($urandom), 8'($urandom), 1'b1);
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
